// File: rtl/vx_fetch_pkg.sv
// vx_fetch_pkg: shared sizing and reset constants for the fetch / warp-scheduling stage.
//   NT       threads per warp (width of thread-valid masks)
//   NW       warps per core; a power of two, at least 2
//   WW       warp-number width, clog2(NW)
//   START_PC PC loaded into every warp at reset
//   PC_STEP  byte increment between consecutive instructions
package vx_fetch_pkg;

    localparam int          NT       = 4;
    localparam int          NW       = 8;
    localparam int          WW       = $clog2(NW);
    localparam logic [31:0] START_PC = 32'h8000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage : vx_fetch_pkg

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: combinational round-robin picker.
// Scans in_last+1, in_last+2, ... wrapping modulo NW and grants the first set request bit.
//   in_req     NW request bits (one per warp)
//   in_last    index granted most recently; the scan starts just after it
//   out_grant  one-hot grant (all zero when no request)
//   out_idx    encoded grant index (0 when no request)
//   out_valid  at least one request was granted
import vx_fetch_pkg::*;

module vx_rr_arbiter #(
    parameter int NW = vx_fetch_pkg::NW,
    parameter int WW = $clog2(NW)
) (
    input  logic [NW-1:0] in_req,
    input  logic [WW-1:0] in_last,
    output logic [NW-1:0] out_grant,
    output logic [WW-1:0] out_idx,
    output logic          out_valid
);

    logic [WW-1:0] w_cand;

    // NOTE: every variable written in this block gets a default first, so no path leaves a latch.
    always_comb begin
        out_grant = '0;
        out_idx   = '0;
        out_valid = 1'b0;
        w_cand    = '0;
        // NW is a power of two, so the WW-bit add wraps naturally; i == NW lands back on in_last.
        for (int i = 1; i <= NW; i++) begin
            w_cand = in_last + WW'(i);
            if (!out_valid && in_req[w_cand]) begin
                out_valid         = 1'b1;
                out_idx           = w_cand;
                out_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule : vx_rr_arbiter

// File: rtl/vx_fetch.sv
// vx_fetch: instruction fetch and warp scheduler feeding the fetch-to-decode register.
// Keeps per-warp PC, thread mask, active and stalled state; picks one eligible warp per cycle
// round-robin and presents its PC to the icache and its instruction/PC/mask/number to decode.
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   in_fwd_stall/in_freeze/in_clone_stall  downstream hold (any one freezes issue-side state)
//   in_decode_branch_stall, in_decode_warp_num  decode holds a control-flow op of that warp
//   in_branch_*                execute resolved a branch; clears stall, optionally redirects
//   in_tmc_*                   thread-mask update; an all-zero mask deactivates the warp
//   in_wspawn, in_wspawn_pc    activate every inactive warp other than warp 0
//   in_icache_instruction      combinational icache data for out_icache_pc
//   out_icache_pc, out_instruction, out_curr_PC, out_valid, out_warp_num  issue to decode
//   out_busy                   any warp active
import vx_fetch_pkg::*;

module vx_fetch #(
    parameter int          NT       = vx_fetch_pkg::NT,
    parameter int          NW       = vx_fetch_pkg::NW,
    parameter int          WW       = $clog2(NW),
    parameter logic [31:0] START_PC = vx_fetch_pkg::START_PC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_fwd_stall,
    input  logic          in_freeze,
    input  logic          in_clone_stall,
    input  logic          in_decode_branch_stall,
    input  logic [WW-1:0] in_decode_warp_num,
    input  logic          in_branch_valid,
    input  logic          in_branch_taken,
    input  logic [31:0]   in_branch_dest,
    input  logic [WW-1:0] in_branch_warp_num,
    input  logic          in_tmc_valid,
    input  logic [WW-1:0] in_tmc_warp_num,
    input  logic [NT-1:0] in_tmc_mask,
    input  logic          in_wspawn,
    input  logic [31:0]   in_wspawn_pc,
    input  logic [31:0]   in_icache_instruction,
    output logic [31:0]   out_icache_pc,
    output logic [31:0]   out_instruction,
    output logic [31:0]   out_curr_PC,
    output logic [NT-1:0] out_valid,
    output logic [WW-1:0] out_warp_num,
    output logic          out_busy
);

    logic [31:0]   r_pc      [NW];
    logic [NT-1:0] r_mask    [NW];
    logic [NW-1:0] r_active;
    logic [NW-1:0] r_stalled;
    logic [WW-1:0] r_last;

    logic [NW-1:0] w_eligible;
    logic [NW-1:0] w_grant;
    logic [WW-1:0] w_sel;
    logic          w_any;
    logic          w_hold;
    logic          w_issue;

    // The decode-branch exclusion is same-cycle so a warp is never reissued behind its own branch.
    always_comb begin
        w_eligible = '0;
        for (int w = 0; w < NW; w++) begin
            w_eligible[w] = r_active[w] & ~r_stalled[w]
                          & ~(in_decode_branch_stall && (in_decode_warp_num == WW'(w)));
        end
    end

    vx_rr_arbiter #(.NW(NW), .WW(WW)) u_arb (
        .in_req    (w_eligible),
        .in_last   (r_last),
        .out_grant (w_grant),
        .out_idx   (w_sel),
        .out_valid (w_any)
    );

    assign w_hold  = in_fwd_stall | in_freeze | in_clone_stall;
    assign w_issue = w_any & ~w_hold;

    // Outputs track the selection even while held; the decode register ignores them then.
    assign out_icache_pc   = w_any ? r_pc[w_sel] : 32'd0;
    assign out_curr_PC     = out_icache_pc;
    assign out_valid       = w_any ? r_mask[w_sel] : '0;
    assign out_warp_num    = w_any ? w_sel : '0;
    assign out_instruction = w_any ? in_icache_instruction : 32'd0;
    assign out_busy        = |r_active;

    // NOTE: non-blocking updates; within one warp the later assignment wins, so the statement
    // order below encodes priority: redirect > wspawn > increment for pc, decode-stall set >
    // branch clear for stalled, tmc > wspawn for mask/active.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NW; w++) begin
                r_pc[w]   <= START_PC;
                r_mask[w] <= (w == 0) ? NT'(1) : '0;
            end
            r_active  <= NW'(1);
            r_stalled <= '0;
            r_last    <= WW'(NW - 1);
        end else begin
            if (w_issue) begin
                r_pc[w_sel] <= r_pc[w_sel] + PC_STEP;
                r_last      <= w_sel;
            end
            for (int w = 0; w < NW; w++) begin
                if (in_wspawn && (w != 0) && !r_active[w]) begin
                    r_active[w]  <= 1'b1;
                    r_mask[w]    <= NT'(1);
                    r_pc[w]      <= in_wspawn_pc;
                    r_stalled[w] <= 1'b0;
                end
                if (in_tmc_valid && (in_tmc_warp_num == WW'(w))) begin
                    r_mask[w]   <= in_tmc_mask;
                    r_active[w] <= |in_tmc_mask;
                end
                if (in_branch_valid && (in_branch_warp_num == WW'(w))) begin
                    r_stalled[w] <= 1'b0;
                    if (in_branch_taken) begin
                        r_pc[w] <= in_branch_dest;
                    end
                end
                if (in_decode_branch_stall && (in_decode_warp_num == WW'(w))) begin
                    r_stalled[w] <= 1'b1;
                end
            end
        end
    end

endmodule : vx_fetch

// File: tb/tb_vx_fetch.sv
// tb_vx_fetch: directed self-checking bench for vx_fetch.
// Inputs change 2 ns after each rising edge; outputs are sampled 4 ns after it.
module tb_vx_fetch;
    import vx_fetch_pkg::*;

    localparam logic [31:0] ICACHE_XOR = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_fwd_stall, in_freeze, in_clone_stall;
    logic          in_decode_branch_stall;
    logic [WW-1:0] in_decode_warp_num;
    logic          in_branch_valid, in_branch_taken;
    logic [31:0]   in_branch_dest;
    logic [WW-1:0] in_branch_warp_num;
    logic          in_tmc_valid;
    logic [WW-1:0] in_tmc_warp_num;
    logic [NT-1:0] in_tmc_mask;
    logic          in_wspawn;
    logic [31:0]   in_wspawn_pc;
    logic [31:0]   in_icache_instruction;
    logic [31:0]   out_icache_pc, out_instruction, out_curr_PC;
    logic [NT-1:0] out_valid;
    logic [WW-1:0] out_warp_num;
    logic          out_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Icache model: data is a fixed function of the address.
    assign in_icache_instruction = out_icache_pc ^ ICACHE_XOR;

    vx_fetch dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_fwd_stall           (in_fwd_stall),
        .in_freeze              (in_freeze),
        .in_clone_stall         (in_clone_stall),
        .in_decode_branch_stall (in_decode_branch_stall),
        .in_decode_warp_num     (in_decode_warp_num),
        .in_branch_valid        (in_branch_valid),
        .in_branch_taken        (in_branch_taken),
        .in_branch_dest         (in_branch_dest),
        .in_branch_warp_num     (in_branch_warp_num),
        .in_tmc_valid           (in_tmc_valid),
        .in_tmc_warp_num        (in_tmc_warp_num),
        .in_tmc_mask            (in_tmc_mask),
        .in_wspawn              (in_wspawn),
        .in_wspawn_pc           (in_wspawn_pc),
        .in_icache_instruction  (in_icache_instruction),
        .out_icache_pc          (out_icache_pc),
        .out_instruction        (out_instruction),
        .out_curr_PC            (out_curr_PC),
        .out_valid              (out_valid),
        .out_warp_num           (out_warp_num),
        .out_busy               (out_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Checks every issue output against one expected issue (valid==0 means bubble).
    task automatic expect_issue(input string tag, input logic [NT-1:0] valid,
                                input int warp, input logic [31:0] pc);
        logic [31:0] exp_pc;
        exp_pc = (valid != '0) ? pc : 32'd0;
        check({tag, ".valid"}, 32'(out_valid), 32'(valid));
        check({tag, ".warp"},  32'(out_warp_num), (valid != '0) ? 32'(warp) : 32'd0);
        check({tag, ".pc"},    out_curr_PC, exp_pc);
        check({tag, ".ipc"},   out_icache_pc, exp_pc);
        check({tag, ".instr"}, out_instruction, (valid != '0) ? (pc ^ ICACHE_XOR) : 32'd0);
    endtask

    // Advance to 2 ns after the next rising edge (the input-drive point).
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_events();
        in_decode_branch_stall = 1'b0;
        in_branch_valid        = 1'b0;
        in_branch_taken        = 1'b0;
        in_tmc_valid           = 1'b0;
        in_wspawn              = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {in_fwd_stall, in_freeze, in_clone_stall} = 3'b000;
        clear_events();
        in_decode_warp_num = '0;
        in_branch_dest     = '0;
        in_branch_warp_num = '0;
        in_tmc_warp_num    = '0;
        in_tmc_mask        = '0;
        in_wspawn_pc       = '0;

        // Reset, then three issues of warp 0.
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #2;
        check("rst.busy", 32'(out_busy), 32'd1);
        expect_issue("rst.i0", 4'b0001, 0, 32'h8000_0000);
        next_cycle(); #2;
        expect_issue("rst.i1", 4'b0001, 0, 32'h8000_0004);
        next_cycle(); #2;
        expect_issue("rst.i2", 4'b0001, 0, 32'h8000_0008);

        // Spawn at 0x100 while warp 0 issues 8000_000C, then round-robin through all warps.
        next_cycle();
        in_wspawn    = 1'b1;
        in_wspawn_pc = 32'h0000_0100;
        #2;
        expect_issue("spawn.i0", 4'b0001, 0, 32'h8000_000C);
        next_cycle();
        clear_events();
        #2;
        for (int w = 1; w < NW; w++) begin
            expect_issue($sformatf("rr.w%0d", w), 4'b0001, w, 32'h0000_0100);
            next_cycle(); #2;
        end
        expect_issue("rr.w0", 4'b0001, 0, 32'h8000_0010);
        next_cycle(); #2;
        expect_issue("rr.w1b", 4'b0001, 1, 32'h0000_0104);

        // Freeze two cycles: warp 2 at 0x104 stays presented, then issues and moves on.
        next_cycle();
        in_freeze = 1'b1;
        #2;
        expect_issue("frz.c0", 4'b0001, 2, 32'h0000_0104);
        next_cycle(); #2;
        expect_issue("frz.c1", 4'b0001, 2, 32'h0000_0104);
        next_cycle();
        in_freeze = 1'b0;
        #2;
        expect_issue("frz.rel", 4'b0001, 2, 32'h0000_0104);
        next_cycle(); #2;
        expect_issue("frz.next", 4'b0001, 3, 32'h0000_0104);

        // Reset mid-stream with a taken branch and wspawn also high: only reset effects survive.
        next_cycle();
        reset              = 1'b0;
        in_branch_valid    = 1'b1;
        in_branch_taken    = 1'b1;
        in_branch_warp_num = '0;
        in_branch_dest     = 32'h0000_0300;
        in_wspawn          = 1'b1;
        in_wspawn_pc       = 32'h0000_0500;
        next_cycle();
        reset = 1'b1;
        clear_events();
        #2;
        expect_issue("mrst.i0", 4'b0001, 0, 32'h8000_0000);
        next_cycle(); #2;
        expect_issue("mrst.i1", 4'b0001, 0, 32'h8000_0004);

        // Decode stall on warp 0 in the same cycle: bubble, and warp 0 stays stalled.
        in_decode_branch_stall = 1'b1;
        in_decode_warp_num     = '0;
        #0;
        expect_issue("dstall.same", '0, 0, 32'd0);
        next_cycle();
        clear_events();
        #2;
        expect_issue("dstall.held", '0, 0, 32'd0);
        check("dstall.busy", 32'(out_busy), 32'd1);

        // Branch resolves taken to 0x200 while fwd_stall is high.
        next_cycle();
        in_fwd_stall       = 1'b1;
        in_branch_valid    = 1'b1;
        in_branch_taken    = 1'b1;
        in_branch_warp_num = '0;
        in_branch_dest     = 32'h0000_0200;
        #2;
        expect_issue("br.during", '0, 0, 32'd0);
        next_cycle();
        in_fwd_stall = 1'b0;
        clear_events();
        #2;
        expect_issue("br.redir", 4'b0001, 0, 32'h0000_0200);

        // tmc mask=0 on warp 0 while it issues 0x204: stage goes idle.
        next_cycle();
        in_tmc_valid    = 1'b1;
        in_tmc_warp_num = '0;
        in_tmc_mask     = 4'b0000;
        #2;
        expect_issue("tmc0.last", 4'b0001, 0, 32'h0000_0204);
        next_cycle();
        clear_events();
        #2;
        check("tmc0.busy", 32'(out_busy), 32'd0);
        expect_issue("tmc0.idle", '0, 0, 32'd0);

        // tmc mask=1111 together with a redirect to 0x400.
        next_cycle();
        check("tmc0.busy2", 32'(out_busy), 32'd0);
        in_tmc_valid       = 1'b1;
        in_tmc_warp_num    = '0;
        in_tmc_mask        = 4'b1111;
        in_branch_valid    = 1'b1;
        in_branch_taken    = 1'b1;
        in_branch_warp_num = '0;
        in_branch_dest     = 32'h0000_0400;
        #2;
        expect_issue("tmc0.idle2", '0, 0, 32'd0);
        next_cycle();
        clear_events();
        #2;
        check("tmcF.busy", 32'(out_busy), 32'd1);
        expect_issue("tmcF.i0", 4'b1111, 0, 32'h0000_0400);
        next_cycle(); #2;
        expect_issue("tmcF.i1", 4'b1111, 0, 32'h0000_0404);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vx_fetch
